// File: rtl/clk_period_monitor_pkg.sv
// rtl/clk_period_monitor_pkg.sv - shared types and default period limits for the clock period monitor
package clk_period_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOST    = 2'd2
  } state_e;

  // 50 MHz system clock over the 1 MHz divided motor clock, with +/-2 cycles of slack
  localparam int NOM_PERIOD = 50;
  localparam int MIN_PERIOD = NOM_PERIOD - 2;
  localparam int MAX_PERIOD = NOM_PERIOD + 2;

endpackage

// File: rtl/clk_period_monitor_sync_edge_det.sv
// rtl/clk_period_monitor_sync_edge_det.sv - two-flop synchroniser with rising-edge pulse
module sync_edge_det (
  input  logic clk_i,
  input  logic nRst,
  input  logic sig_i,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q, hist_d;

  // shift chain: two metastability stages, then one history stage for edge detection
  always_comb begin
    sync1_d = sig_i;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // synchroniser and history registers
  always_ff @(posedge clk_i or negedge nRst) begin
    if (!nRst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rise_o = sync2_q & ~hist_q;

endmodule

// File: rtl/clk_period_monitor.sv
// rtl/clk_period_monitor.sv - measures a slow asynchronous clock's period and reports lock/loss/errors
module clk_period_monitor #(
  parameter int CNT_W      = 8,
  parameter int MIN_PERIOD = clk_period_monitor_pkg::MIN_PERIOD,
  parameter int MAX_PERIOD = clk_period_monitor_pkg::MAX_PERIOD,
  parameter int TIMEOUT    = 200,
  parameter int LOCK_N     = 4
) (
  input  logic             clk50mhzI,
  input  logic             nRst,
  input  logic             clkMonI,
  output logic [CNT_W-1:0] periodO,
  output logic             periodVldO,
  output logic             lockO,
  output logic             lossO,
  output logic [7:0]       errCntO
);
  import clk_period_monitor_pkg::*;

  localparam int                GOOD_W  = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  MIN_C   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  MAX_C   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]  TMO_C   = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_C  = GOOD_W'(LOCK_N);

  logic rise;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [GOOD_W-1:0]  good_inc;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               period_vld_q, period_vld_d;
  logic               lock_q, lock_d;
  logic               loss_q, loss_d;
  logic [7:0]         err_q, err_d;
  logic               in_range;

  sync_edge_det u_sync (
    .clk_i  (clk50mhzI),
    .nRst   (nRst),
    .sig_i  (clkMonI),
    .rise_o (rise)
  );

  // cycles since the last rise; restarts at 1 on a rise and sticks at all-ones
  always_comb begin
    if (rise) begin
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // next state and output register values; a rise beats a simultaneous timeout
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    lock_d       = lock_q;
    loss_d       = loss_q;
    err_d        = err_q;
    in_range     = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
    good_inc     = (good_q == LOCK_C) ? good_q : good_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (rise) begin
          period_d     = cnt_q;
          period_vld_d = 1'b1;
          if (in_range) begin
            good_d = good_inc;
            lock_d = (good_inc == LOCK_C);
          end else begin
            good_d = '0;
            lock_d = 1'b0;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end else if (cnt_q == TMO_C) begin
          state_d = ST_LOST;
          loss_d  = 1'b1;
          lock_d  = 1'b0;
          good_d  = '0;
        end
      end
      ST_LOST: begin
        if (rise) begin
          state_d = ST_MEASURE;
          loss_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge clk50mhzI or negedge nRst) begin
    if (!nRst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      good_q       <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      lock_q       <= 1'b0;
      loss_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      lock_q       <= lock_d;
      loss_q       <= loss_d;
      err_q        <= err_d;
    end
  end

  assign periodO    = period_q;
  assign periodVldO = period_vld_q;
  assign lockO      = lock_q;
  assign lossO      = loss_q;
  assign errCntO    = err_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb/tb_clk_period_monitor.sv - randomized self-checking bench for clk_period_monitor
module tb_clk_period_monitor;

  localparam int TIMEOUT = 200;
  localparam int MIN_P   = 48;
  localparam int MAX_P   = 52;
  localparam int LOCK_N  = 4;

  logic       clk;
  logic       nRst;
  logic       clkMonI;
  logic [7:0] periodO;
  logic       periodVldO;
  logic       lockO;
  logic       lossO;
  logic [7:0] errCntO;

  int     n_vec = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  typedef struct {longint cyc; int per; bit lock; int err;} strobe_t;
  typedef struct {longint cyc; bit val; bit lock;} lossev_t;

  strobe_t got_s[$];
  lossev_t got_l[$];
  longint  edges[$];
  bit      loss_prev = 1'b0;

  clk_period_monitor dut (
    .clk50mhzI  (clk),
    .nRst       (nRst),
    .clkMonI    (clkMonI),
    .periodO    (periodO),
    .periodVldO (periodVldO),
    .lockO      (lockO),
    .lossO      (lossO),
    .errCntO    (errCntO)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // record every strobe and every loss transition with the cycle it was seen in
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (periodVldO === 1'b1) got_s.push_back('{cyc, int'(periodO), lockO, int'(errCntO)});
      if (lossO !== loss_prev) begin
        got_l.push_back('{cyc, lossO, lockO});
        loss_prev = lossO;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // one monitored period starting at the current negedge: h cycles high, l cycles low
  task automatic drive_period(input int h, input int l);
    clkMonI = 1'b1;
    edges.push_back(cyc);
    repeat (h) @(negedge clk);
    clkMonI = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic drive_gap(input int g);
    int h;
    h = $urandom_range(2, g - 2);
    drive_period(h, g - h);
  endtask

  task automatic do_reset(input bit chk);
    @(posedge clk);
    #5 nRst = 1'b0;
    #1;
    if (chk) begin
      check_eq("rst periodO", periodO, 0);
      check_eq("rst periodVldO", periodVldO, 0);
      check_eq("rst lockO", lockO, 0);
      check_eq("rst lossO", lossO, 0);
      check_eq("rst errCntO", errCntO, 0);
    end
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    @(posedge clk);
    #2;
    got_s.delete();
    got_l.delete();
    edges.delete();
    @(negedge clk);
  endtask

  // reference model: derive strobes and loss events from the list of edge cycles
  task automatic check_segment(input string name);
    strobe_t exp_s[$];
    lossev_t exp_l[$];
    int      good_run, err, n;
    bit      have_ref;
    longint  prev, e, gap;
    good_run = 0;
    err      = 0;
    have_ref = 1'b0;
    prev     = 0;
    foreach (edges[i]) begin
      e = edges[i];
      if (!have_ref) begin
        have_ref = 1'b1;
      end else begin
        gap = e - prev;
        if (gap > TIMEOUT) begin
          exp_l.push_back('{prev + 3 + TIMEOUT, 1'b1, 1'b0});
          exp_l.push_back('{e + 3, 1'b0, 1'b0});
          good_run = 0;
        end else begin
          if (gap >= MIN_P && gap <= MAX_P) begin
            good_run++;
          end else begin
            good_run = 0;
            if (err < 255) err++;
          end
          exp_s.push_back('{e + 3, int'(gap), good_run >= LOCK_N, err});
        end
      end
      prev = e;
    end
    if (have_ref && cyc >= prev + 3 + TIMEOUT) exp_l.push_back('{prev + 3 + TIMEOUT, 1'b1, 1'b0});

    check_eq({name, " strobe count"}, got_s.size(), exp_s.size());
    n = (got_s.size() < exp_s.size()) ? got_s.size() : exp_s.size();
    for (int i = 0; i < n; i++) begin
      check_eq({name, " strobe cycle"}, got_s[i].cyc, exp_s[i].cyc);
      check_eq({name, " periodO"}, got_s[i].per, exp_s[i].per);
      check_eq({name, " lockO"}, got_s[i].lock, exp_s[i].lock);
      check_eq({name, " errCntO"}, got_s[i].err, exp_s[i].err);
    end
    check_eq({name, " loss event count"}, got_l.size(), exp_l.size());
    n = (got_l.size() < exp_l.size()) ? got_l.size() : exp_l.size();
    for (int i = 0; i < n; i++) begin
      check_eq({name, " loss cycle"}, got_l[i].cyc, exp_l[i].cyc);
      check_eq({name, " lossO"}, got_l[i].val, exp_l[i].val);
      check_eq({name, " lockO at loss"}, got_l[i].lock, exp_l[i].lock);
    end
  endtask

  initial begin
    int bnd[] = '{50, 50, 50, 50, 47, 48, 52, 53, 50, 50, 50, 50, 200,
                  50, 50, 50, 50, 201, 50, 50, 50, 50, 50};
    int g, r, nper;

    nRst    = 1'b0;
    clkMonI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset periodO", periodO, 0);
    check_eq("reset periodVldO", periodVldO, 0);
    check_eq("reset lockO", lockO, 0);
    check_eq("reset lossO", lossO, 0);
    check_eq("reset errCntO", errCntO, 0);
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk);
    #2;
    got_s.delete();
    got_l.delete();
    @(negedge clk);

    // ideal clock, one short period, relock, stop/restart, relock
    repeat (10) drive_period(25, 25);
    drive_period(20, 20);
    repeat (5) drive_period(25, 25);
    drive_period(25, 235);
    repeat (6) drive_period(25, 25);
    repeat (6) @(negedge clk);
    check_eq("lock before mid reset", lockO, 1);
    check_segment("directed");
    do_reset(1'b1);

    // long run of out-of-range periods saturates the error counter
    repeat (300) drive_period(30, 30);
    repeat (4) @(negedge clk);
    check_eq("errCntO saturated", errCntO, 255);
    check_segment("saturate");
    do_reset(1'b0);

    // range edges and timeout boundary
    foreach (bnd[i]) drive_period(bnd[i] / 2, bnd[i] - bnd[i] / 2);
    repeat (5) @(negedge clk);
    check_segment("boundary");
    do_reset(1'b0);

    // random mixes of good, bad and lost periods
    for (int s = 0; s < 5; s++) begin
      nper = $urandom_range(15, 40);
      for (int p = 0; p < nper; p++) begin
        r = $urandom_range(0, 99);
        if (r < 70)      g = $urandom_range(MIN_P, MAX_P);
        else if (r < 90) g = $urandom_range(8, 120);
        else             g = $urandom_range(TIMEOUT - 2, TIMEOUT + 40);
        drive_gap(g);
      end
      repeat (5) @(negedge clk);
      check_segment("random");
      do_reset(1'b0);
    end

    // asynchronous 1 MHz input at every 1 ns phase offset
    for (int off = 0; off < 20; off++) begin
      do_reset(1'b0);
      @(posedge clk);
      #(off);
      repeat (6) begin
        clkMonI = 1'b1;
        #500;
        clkMonI = 1'b0;
        #500;
      end
      repeat (4) @(negedge clk);
      check_eq("sweep strobe count", got_s.size(), 5);
      foreach (got_s[i]) check_eq("sweep period in 49..51", (got_s[i].per >= 49 && got_s[i].per <= 51), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
